// File: rtl/pc_fetch_ctrl.sv
// Program-counter and instruction-fetch sequencer: BOOT -> FETCH <-> ISSUE, with an optional TRAP.
// Define PC_MISALIGN_TRAP_EN to trap on a misaligned next-PC instead of masking its low bits.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          BOOT_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCp2,
  input  logic        stall,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] PCP,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] Instr,
  output logic        instr_valid,
  output logic        misalign_err
);

  typedef enum logic [1:0] {BOOT, FETCH, ISSUE, TRAP} state_t;

  localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [7:0]  boot_cnt_reg, boot_cnt_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic        err_reg, err_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= BOOT;
      boot_cnt_reg <= 8'd0;
      pc_reg       <= RESET_VECTOR;
      instr_reg    <= 32'h0000_0000;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      boot_cnt_reg <= boot_cnt_next;
      pc_reg       <= pc_next;
      instr_reg    <= instr_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    boot_cnt_next = boot_cnt_reg;
    pc_next       = pc_reg;
    instr_next    = instr_reg;
    err_next      = err_reg;
    case (state_reg)
      BOOT: begin
        if (boot_cnt_reg == BOOT_LAST) begin
          state_next    = FETCH;
          boot_cnt_next = 8'd0;
        end else begin
          boot_cnt_next = boot_cnt_reg + 8'd1;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          instr_next = imem_rdata;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (!stall) begin
`ifdef PC_MISALIGN_TRAP_EN
          // A misaligned target freezes the PC at the offending instruction
          if (PCp2[1:0] != 2'b00) begin
            err_next   = 1'b1;
            state_next = TRAP;
          end else begin
            pc_next    = PCp2;
            state_next = FETCH;
          end
`else
          pc_next    = PCp2 & ~32'h0000_0003;
          state_next = FETCH;
`endif
        end
      end
      default: begin
        state_next = TRAP;
      end
    endcase
  end

  // Request/valid decode straight from state so reset drops them without a clock edge
  assign imem_req     = (state_reg == FETCH);
  assign instr_valid  = (state_reg == ISSUE);
  assign imem_addr    = pc_reg;
  assign PC           = pc_reg;
  assign PCP          = pc_reg + 32'd4;
  assign Instr        = instr_reg;
  assign misalign_err = err_reg;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Randomized bench for pc_fetch_ctrl against a transaction-level model, plus directed literal checks.
module tb_pc_fetch_ctrl;

  localparam int BOOT_CYCLES = 4;
`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCp2;
  logic        stall;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] PC, PCP, imem_addr, Instr;
  logic        imem_req, instr_valid, misalign_err;

  int total = 0;
  int bad   = 0;

  // Model: cycles left in boot, whether an instruction is being held for issue, trap flag
  logic [31:0] m_pc, m_instr;
  int          boot_left;
  bit          m_hold, m_trap, m_err;

  pc_fetch_ctrl #(.RESET_VECTOR(32'h0000_0000), .BOOT_CYCLES(BOOT_CYCLES)) dut (
    .clk(clk), .rst(rst), .PCp2(PCp2), .stall(stall), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .PC(PC), .PCP(PCP), .imem_req(imem_req),
    .imem_addr(imem_addr), .Instr(Instr), .instr_valid(instr_valid),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; boot_left = BOOT_CYCLES;
    m_hold = 1'b0; m_trap = 1'b0; m_err = 1'b0;
  endtask

  task automatic check_model();
    bit exp_req;
    exp_req = !m_trap && boot_left == 0 && !m_hold;
    chk("PC", PC, m_pc);
    chk("PCP", PCP, m_pc + 32'd4);
    chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("Instr", Instr, m_instr);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_hold});
    chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
  endtask

  // Called at a falling edge: drive inputs, predict the next edge, then check after it
  task automatic step(input bit a, input bit s, input logic [31:0] p);
    imem_ack   = a;
    stall      = s;
    PCp2       = p;
    imem_rdata = a ? mem_word(m_pc) : $urandom;
    if (rst) model_reset();
    else if (boot_left > 0) boot_left--;
    else if (m_trap) begin end
    else if (!m_hold) begin
      if (a) begin m_instr = imem_rdata; m_hold = 1'b1; end
    end else if (!s) begin
      if (TRAP_EN && p[1:0] != 2'b00) begin
        m_trap = 1'b1; m_err = 1'b1; m_hold = 1'b0;
      end else begin
        m_pc = {p[31:2], 2'b00}; m_hold = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    rst = 1'b0;
  endtask

  task automatic count_boot();
    int n = 0;
    while (!imem_req && n < 20) begin
      step(1'b1, 1'b0, m_pc + 32'd4);
      n++;
    end
    chk("boot_edges", n, BOOT_CYCLES);
  endtask

  task automatic go_issue();
    int n = 0;
    while (!instr_valid && n < 20) begin
      step(1'b1, 1'b0, m_pc + 32'd4);
      n++;
    end
    chk("reach_issue", {31'd0, instr_valid}, 32'd1);
  endtask

  initial begin
    logic [31:0] pcs [4];
    logic [31:0] held_instr, held_pc, a0, p;
    int k, n;

    rst = 1'b1; PCp2 = 32'h0; stall = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    model_reset();
    #1;
    chk("rst_PC", PC, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_Instr", Instr, 32'h0);
    chk("rst_err", {31'd0, misalign_err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // First fetch after exactly BOOT_CYCLES edges, issue one cycle later
    count_boot();
    chk("first_addr", imem_addr, 32'h0);
    step(1'b1, 1'b0, m_pc + 32'd4);
    chk("first_valid", {31'd0, instr_valid}, 32'd1);
    chk("first_instr", Instr, mem_word(32'h0));

    // Sequential run: issued PCs 0,4,8,12
    k = 0; n = 0;
    while (k < 4 && n < 40) begin
      if (instr_valid) begin pcs[k] = PC; k++; end
      if (k < 4) step(1'b1, 1'b0, m_pc + 32'd4);
      n++;
    end
    for (int i = 0; i < 4; i++) chk("seq_pc", pcs[i], 32'(i * 4));
    step(1'b1, 1'b0, m_pc + 32'd4);

    // Delayed ack: request held 4 cycles with a stable address
    n = 0;
    while (!imem_req && n < 20) begin step(1'b0, 1'b0, m_pc + 32'd4); n++; end
    a0 = imem_addr;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0);
      chk("delay_req", {31'd0, imem_req}, 32'd1);
      chk("delay_addr", imem_addr, a0);
      chk("delay_valid", {31'd0, instr_valid}, 32'd0);
    end
    step(1'b1, 1'b0, 32'h0);
    chk("delay_issue", {31'd0, instr_valid}, 32'd1);

    // Stall holds PC and Instr
    held_instr = Instr; held_pc = PC;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 32'h0000_0040);
      chk("stall_instr", Instr, held_instr);
      chk("stall_pc", PC, held_pc);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
    end
    step(1'b0, 1'b0, 32'h0000_0040);
    chk("stall_release_pc", PC, 32'h0000_0040);

    // PC+4 wraps silently
    go_issue();
    step(1'b0, 1'b0, 32'hFFFF_FFFC);
    go_issue();
    chk("wrap_pc", PC, 32'hFFFF_FFFC);
    chk("wrap_pcp", PCP, 32'h0000_0000);
    chk("wrap_err", {31'd0, misalign_err}, 32'd0);
    step(1'b0, 1'b0, m_pc + 32'd4);
    chk("wrap_next", PC, 32'h0000_0000);

    // Randomized traffic with occasional asynchronous reset pulses
    for (int it = 0; it < 3000; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        #2 rst = 1'b1;
        #1 model_reset();
        check_model();
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0);
        rst = 1'b0;
      end
      r = $urandom_range(0, 99);
      if (r < 70)      p = m_pc + 32'd4;
      else if (r < 85) p = $urandom & ~32'h3;
      else if (r < 95) p = $urandom;
      else             p = 32'hFFFF_FFFC;
      step(($urandom % 3) != 0, ($urandom % 3) == 0, p);
    end

    // Reset mid-fetch with ack pending
    do_reset();
    n = 0;
    while (!imem_req && n < 20) begin step(1'b0, 1'b0, m_pc + 32'd4); n++; end
    step(1'b0, 1'b0, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_pc", PC, 32'h0);
    model_reset();
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("midrst_instr", Instr, 32'h0);
    rst = 1'b0;
    count_boot();

    // Misaligned target
    go_issue();
    step(1'b0, 1'b0, 32'h0000_0102);
    if (TRAP_EN) begin
      chk("mis_err", {31'd0, misalign_err}, 32'd1);
      for (int i = 0; i < 3; i++) begin
        step(1'b1, 1'b0, 32'h0);
        chk("trap_req", {31'd0, imem_req}, 32'd0);
      end
    end else begin
      chk("mis_pc", PC, 32'h0000_0100);
      chk("mis_err", {31'd0, misalign_err}, 32'd0);
      chk("mis_fetch", {31'd0, imem_req}, 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
